lcd_control: RTL and testbench

- Self-running controller for an HD44780-compatible character LCD in 4-bit mode, as fitted to the Spartan-3E starter board.
- After reset it waits for LCD power-up, then runs the 4-bit initialisation sequence and the configuration commands.
- It then writes the fixed 11-character string "Hello World" at line 1, column 0, and idles.
- Sits at top level, driving the LCD pins directly from a 50 MHz clock. No host interface.

---
 rtl/lcd_if.sv | 25 ++
 rtl/lcd_control.sv | 211 +++++++++++++++++++++
 tb/tb_lcd_control.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/lcd_if.sv
// LCD pin bundle for an HD44780-style display in 4-bit mode.
// The controller drives it (master) and the panel or a monitor observes it (slave).
interface lcd_if;
  logic       oLCD_Enabled;
  logic       oLCD_RegisterSelect;
  logic       oLCD_StrataFlashControl;
  logic       oLCD_ReadWrite;
  logic [3:0] oLCD_Data;

  modport master (
    output oLCD_Enabled,
    output oLCD_RegisterSelect,
    output oLCD_StrataFlashControl,
    output oLCD_ReadWrite,
    output oLCD_Data
  );

  modport slave (
    input oLCD_Enabled,
    input oLCD_RegisterSelect,
    input oLCD_StrataFlashControl,
    input oLCD_ReadWrite,
    input oLCD_Data
  );
endinterface

// File: rtl/lcd_control.sv
// Self-running HD44780 4-bit controller: power-up wait, init, config,
// then writes "Hello World" at line 1 column 0 and idles.
module lcd_control #(
  parameter int P_POWERUP    = 750000,
  parameter int P_WAIT_4100  = 205000,
  parameter int P_WAIT_100   = 5000,
  parameter int P_CMD_WAIT   = 2000,
  parameter int P_CLEAR_WAIT = 82000,
  parameter int P_NIBBLE_GAP = 50,
  parameter int P_EN_WIDTH   = 12
) (
  input  logic Clock,
  input  logic Reset,
  lcd_if.master lcd
);

  function automatic int maxOf(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAXW = maxOf(maxOf(P_POWERUP, P_WAIT_4100),
                              maxOf(P_CLEAR_WAIT, P_CMD_WAIT));
  localparam int CW   = maxOf(20, $clog2(MAXW + 1));

  localparam logic [CW-1:0] kPowLast   = CW'(P_POWERUP - 1);
  localparam logic [CW-1:0] k4100Last  = CW'(P_WAIT_4100 - 1);
  localparam logic [CW-1:0] k100Last   = CW'(P_WAIT_100 - 1);
  localparam logic [CW-1:0] kCmdLast   = CW'(P_CMD_WAIT - 1);
  localparam logic [CW-1:0] kClearLast = CW'(P_CLEAR_WAIT - 1);
  localparam logic [CW-1:0] kGapLast   = CW'(P_NIBBLE_GAP - 1);
  localparam logic [CW-1:0] kEnLast    = CW'(P_EN_WIDTH - 1);

  typedef enum logic [3:0] {
    sPowerup, sInit1, sInit2, sInit3, sInit4,
    sCfg, sAddr, sWrite, sDone
  } state_t;

  typedef enum logic [1:0] {
    pSetup, pStrobe, pHold
  } phase_t;

  state_t        state, stateN;
  phase_t        phase, phaseN;
  logic [CW-1:0] cnt, cntN;
  logic          hiNib, hiNibN;
  logic [3:0]    idx, idxN;

  logic          enReg, rsReg;
  logic [3:0]    dataReg;

  logic [7:0]    curByte;
  logic [CW-1:0] byteLast, initLast, waitLast;
  logic [3:0]    initNib, nibVal;
  logic          rsVal, isByte, active;

  // Byte/nibble and wait length selected by the current step
  always_comb begin
    curByte  = 8'h00;
    byteLast = kCmdLast;
    initNib  = 4'h3;
    initLast = kCmdLast;
    rsVal    = 1'b0;
    isByte   = 1'b0;
    active   = 1'b1;
    unique case (state)
      sPowerup: active = 1'b0;
      sInit1:   initLast = k4100Last;
      sInit2:   initLast = k100Last;
      sInit3:   initLast = kCmdLast;
      sInit4:   initNib  = 4'h2;
      sCfg: begin
        isByte = 1'b1;
        unique case (idx)
          4'd0:    curByte = 8'h28;
          4'd1:    curByte = 8'h06;
          4'd2:    curByte = 8'h0C;
          default: begin
            curByte  = 8'h01;
            byteLast = kClearLast;
          end
        endcase
      end
      sAddr: begin
        isByte  = 1'b1;
        curByte = 8'h80;
      end
      sWrite: begin
        isByte = 1'b1;
        rsVal  = 1'b1;
        unique case (idx)
          4'd0:    curByte = 8'h48;
          4'd1:    curByte = 8'h65;
          4'd2:    curByte = 8'h6C;
          4'd3:    curByte = 8'h6C;
          4'd4:    curByte = 8'h6F;
          4'd5:    curByte = 8'h20;
          4'd6:    curByte = 8'h57;
          4'd7:    curByte = 8'h6F;
          4'd8:    curByte = 8'h72;
          4'd9:    curByte = 8'h6C;
          default: curByte = 8'h64;
        endcase
      end
      default: active = 1'b0;
    endcase
    nibVal   = isByte ? (hiNib ? curByte[7:4] : curByte[3:0]) : initNib;
    waitLast = isByte ? (hiNib ? kGapLast : byteLast) : initLast;
  end

  // Next state: step sequencing plus setup/strobe/hold of each nibble
  always_comb begin
    stateN = state;
    phaseN = phase;
    cntN   = cnt + 1'b1;
    hiNibN = hiNib;
    idxN   = idx;
    unique case (state)
      sPowerup: begin
        if (cnt == kPowLast) begin
          stateN = sInit1;
          phaseN = pSetup;
          cntN   = '0;
        end
      end
      sDone: cntN = '0;
      default: begin
        unique case (phase)
          pSetup: begin
            phaseN = pStrobe;
            cntN   = '0;
          end
          pStrobe: begin
            if (cnt == kEnLast) begin
              phaseN = pHold;
              cntN   = '0;
            end
          end
          default: begin
            if (cnt == waitLast) begin
              phaseN = pSetup;
              cntN   = '0;
              if (isByte && hiNib) begin
                hiNibN = 1'b0;
              end else begin
                hiNibN = 1'b1;
                unique case (state)
                  sInit1: stateN = sInit2;
                  sInit2: stateN = sInit3;
                  sInit3: stateN = sInit4;
                  sInit4: begin
                    stateN = sCfg;
                    idxN   = 4'd0;
                  end
                  sCfg: begin
                    if (idx == 4'd3) stateN = sAddr;
                    else             idxN   = idx + 4'd1;
                  end
                  sAddr: begin
                    stateN = sWrite;
                    idxN   = 4'd0;
                  end
                  default: begin
                    if (idx == 4'd10) stateN = sDone;
                    else              idxN   = idx + 4'd1;
                  end
                endcase
              end
            end
          end
        endcase
      end
    endcase
  end

  // Sequencer state and counters
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= sPowerup;
      phase <= pSetup;
      cnt   <= '0;
      hiNib <= 1'b1;
      idx   <= 4'd0;
    end else begin
      state <= stateN;
      phase <= phaseN;
      cnt   <= cntN;
      hiNib <= hiNibN;
      idx   <= idxN;
    end
  end

  // Registered pin drive, one cycle behind the sequencer
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      enReg   <= 1'b0;
      rsReg   <= 1'b0;
      dataReg <= 4'h0;
    end else begin
      enReg   <= active && (phase == pStrobe);
      rsReg   <= active && rsVal;
      dataReg <= active ? nibVal : 4'h0;
    end
  end

  assign lcd.oLCD_Enabled            = enReg;
  assign lcd.oLCD_RegisterSelect     = rsReg;
  assign lcd.oLCD_Data               = dataReg;
  assign lcd.oLCD_ReadWrite          = 1'b0;
  assign lcd.oLCD_StrataFlashControl = 1'b1;

endmodule

// File: tb/tb_lcd_control.sv
// Bench for lcd_control with shrunk delays: decodes every E pulse
// against a table of expected nibbles, widths and spacings.
module tb_lcd_control;

  localparam int P_POWERUP    = 100;
  localparam int P_WAIT_4100  = 60;
  localparam int P_WAIT_100   = 40;
  localparam int P_CMD_WAIT   = 20;
  localparam int P_CLEAR_WAIT = 30;
  localparam int P_NIBBLE_GAP = 10;
  localparam int P_EN_WIDTH   = 4;
  localparam int NPULSE       = 36;

  logic Clock = 1'b1;
  logic Reset = 1'b0;

  lcd_if lcdBus();

  lcd_control #(
    .P_POWERUP   (P_POWERUP),
    .P_WAIT_4100 (P_WAIT_4100),
    .P_WAIT_100  (P_WAIT_100),
    .P_CMD_WAIT  (P_CMD_WAIT),
    .P_CLEAR_WAIT(P_CLEAR_WAIT),
    .P_NIBBLE_GAP(P_NIBBLE_GAP),
    .P_EN_WIDTH  (P_EN_WIDTH)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .lcd  (lcdBus)
  );

  always #10 Clock = ~Clock;

  typedef struct {
    logic       rs;
    logic [3:0] nib;
    int         waitCyc;
  } vec_t;

  typedef struct {
    logic       rs;
    logic [3:0] nib;
    int         width;
  } pulse_t;

  vec_t   vecs[NPULSE];
  int     nv = 0;
  pulse_t falls[$];
  int     rises[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int riseAt = 0;
  int changeErr = 0;
  int constErr = 0;
  logic       prevE = 1'b0;
  logic       prevRs = 1'b0;
  logic [3:0] prevD = 4'h0;

  always @(posedge Clock or posedge Reset) begin
    if (Reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  always @(negedge Clock) begin
    if (lcdBus.oLCD_ReadWrite !== 1'b0 ||
        lcdBus.oLCD_StrataFlashControl !== 1'b1)
      constErr <= constErr + 1;
    if (Reset) begin
      prevE <= 1'b0;
    end else begin
      if (lcdBus.oLCD_Enabled && !prevE) begin
        rises.push_back(cyc);
        riseAt <= cyc;
      end
      if (lcdBus.oLCD_Enabled && prevE &&
          (lcdBus.oLCD_Data != prevD ||
           lcdBus.oLCD_RegisterSelect != prevRs))
        changeErr <= changeErr + 1;
      if (!lcdBus.oLCD_Enabled && prevE)
        falls.push_back('{rs: prevRs, nib: prevD, width: cyc - riseAt});
      prevE  <= lcdBus.oLCD_Enabled;
      prevD  <= lcdBus.oLCD_Data;
      prevRs <= lcdBus.oLCD_RegisterSelect;
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic addVec(input logic rs, input logic [3:0] nib, input int w);
    vecs[nv] = '{rs: rs, nib: nib, waitCyc: w};
    nv++;
  endtask

  task automatic addByte(input logic rs, input logic [7:0] b, input int w);
    addVec(rs, b[7:4], P_NIBBLE_GAP);
    addVec(rs, b[3:0], w);
  endtask

  task automatic checkIdle(input string tag);
    check({tag, "_e"},    lcdBus.oLCD_Enabled, 1'b0);
    check({tag, "_rs"},   lcdBus.oLCD_RegisterSelect, 1'b0);
    check({tag, "_data"}, lcdBus.oLCD_Data, 4'h0);
    check({tag, "_rw"},   lcdBus.oLCD_ReadWrite, 1'b0);
    check({tag, "_sf"},   lcdBus.oLCD_StrataFlashControl, 1'b1);
  endtask

  task automatic waitFalls(input int n, input int budget, input string name);
    int k = 0;
    while (falls.size() < n && k < budget) begin
      @(posedge Clock);
      k++;
    end
    check(name, falls.size(), n);
  endtask

  string msg = "Hello World";

  initial begin
    addVec(1'b0, 4'h3, P_WAIT_4100);
    addVec(1'b0, 4'h3, P_WAIT_100);
    addVec(1'b0, 4'h3, P_CMD_WAIT);
    addVec(1'b0, 4'h2, P_CMD_WAIT);
    addByte(1'b0, 8'h28, P_CMD_WAIT);
    addByte(1'b0, 8'h06, P_CMD_WAIT);
    addByte(1'b0, 8'h0C, P_CMD_WAIT);
    addByte(1'b0, 8'h01, P_CLEAR_WAIT);
    addByte(1'b0, 8'h80, P_CMD_WAIT);
    for (int i = 0; i < msg.len(); i++)
      addByte(1'b1, msg[i], P_CMD_WAIT);

    #1 Reset = 1'b1;
    #14 checkIdle("rst_a");
    #30 checkIdle("rst_b");
    #5 Reset = 1'b0;

    waitFalls(NPULSE, 20000, "pulse_count");
    check("first_rise", rises.size() > 0 ? rises[0] : -1, P_POWERUP + 2);
    for (int i = 0; i < NPULSE; i++) begin
      if (i < falls.size()) begin
        check($sformatf("nib%0d", i),   falls[i].nib,   vecs[i].nib);
        check($sformatf("rs%0d", i),    falls[i].rs,    vecs[i].rs);
        check($sformatf("width%0d", i), falls[i].width, P_EN_WIDTH);
      end
      if (i + 1 < NPULSE && i + 1 < rises.size())
        check($sformatf("gap%0d", i), rises[i+1] - rises[i],
              1 + P_EN_WIDTH + vecs[i].waitCyc);
    end

    repeat (10000) @(posedge Clock);
    @(negedge Clock);
    check("idle_rises", rises.size(), NPULSE);
    check("idle_falls", falls.size(), NPULSE);
    #1 checkIdle("done");

    @(negedge Clock) Reset = 1'b1;
    repeat (3) @(negedge Clock);
    falls.delete();
    rises.delete();
    Reset = 1'b0;
    begin
      int k = 0;
      while (rises.size() < 21 && k < 20000) begin
        @(negedge Clock);
        k++;
      end
    end
    check("reach_char4", rises.size() >= 21, 1'b1);
    #1 check("e_before_rst", lcdBus.oLCD_Enabled, 1'b1);
    check("rs_before_rst", lcdBus.oLCD_RegisterSelect, 1'b1);
    #1 Reset = 1'b1;
    #1 checkIdle("async_rst");
    repeat (3) @(negedge Clock);
    falls.delete();
    rises.delete();
    Reset = 1'b0;
    waitFalls(1, 1000, "restart_pulse");
    check("restart_rise", rises.size() > 0 ? rises[0] : -1, P_POWERUP + 2);
    if (falls.size() > 0) begin
      check("restart_nib", falls[0].nib, 4'h3);
      check("restart_rs",  falls[0].rs,  1'b0);
    end

    check("stable_while_e", changeErr, 0);
    check("const_pins", constErr, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
